// File: rtl/up_bus_router.sv
// up_* fan-out router: window decode, one read and one write in flight.
// Optional slave timeout: define UP_BUS_ROUTER_TIMEOUT_EN.
module up_bus_router #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned WINDOW_BITS    = 8,
  parameter int unsigned BASE_INDEX     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADDEAD
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic                       up_wreq,
  input  logic [ADDR_WIDTH-1:0]      up_waddr,
  input  logic [31:0]                up_wdata,
  output logic                       up_wack,
  input  logic                       up_rreq,
  input  logic [ADDR_WIDTH-1:0]      up_raddr,
  output logic [31:0]                up_rdata,
  output logic                       up_rack,
  output logic [NUM_SLAVES-1:0]      s_wreq,
  output logic [ADDR_WIDTH-1:0]      s_waddr,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES-1:0]      s_wack,
  output logic [NUM_SLAVES-1:0]      s_rreq,
  output logic [ADDR_WIDTH-1:0]      s_raddr,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_rack,
  output logic [15:0]                up_timeout_count,
  output logic [2:0]                 up_err_flags
);

  localparam int unsigned IW = ADDR_WIDTH - WINDOW_BITS;
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
`ifdef UP_BUS_ROUTER_TIMEOUT_EN
  localparam bit LP_TO_EN = 1'b1;
`else
  localparam bit LP_TO_EN = 1'b0;
`endif
  localparam logic [15:0] LP_TLIM = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACK} r_st_t;

  // Range check on the raw window index so low windows never wrap in.
  function automatic logic f_map(input logic [IW-1:0] win);
    return (32'(win) >= BASE_INDEX) &&
           (32'(win) < BASE_INDEX + NUM_SLAVES);
  endfunction

  function automatic logic [SW-1:0] f_idx(input logic [IW-1:0] win);
    return SW'(32'(win) - BASE_INDEX);
  endfunction

  w_st_t                 r_wst;
  r_st_t                 r_rst;
  logic [SW-1:0]         r_widx, r_ridx;
  logic                  r_wunm, r_runm;
  logic [15:0]           r_wcnt, r_rcnt;

  logic                  w_wmap, w_rmap;
  logic [SW-1:0]         w_widx, w_ridx;
  logic [NUM_SLAVES-1:0] w_woh, w_roh;
  logic [NUM_SLAVES-1:0] w_wsel, w_rsel;
  logic                  w_wack_sel, w_wack_oth;
  logic                  w_rack_sel, w_rack_oth;
  logic                  w_wto, w_rto;
  logic [31:0]           w_rsd;
  logic [2:0]            w_err;
  logic [16:0]           w_tosum;

  assign w_wmap = f_map(up_waddr[ADDR_WIDTH-1:WINDOW_BITS]);
  assign w_rmap = f_map(up_raddr[ADDR_WIDTH-1:WINDOW_BITS]);
  assign w_widx = f_idx(up_waddr[ADDR_WIDTH-1:WINDOW_BITS]);
  assign w_ridx = f_idx(up_raddr[ADDR_WIDTH-1:WINDOW_BITS]);
  assign w_woh  = NUM_SLAVES'(1) << w_widx;
  assign w_roh  = NUM_SLAVES'(1) << w_ridx;
  assign w_wsel = NUM_SLAVES'(1) << r_widx;
  assign w_rsel = NUM_SLAVES'(1) << r_ridx;

  assign w_wack_sel = |(s_wack & w_wsel);
  assign w_wack_oth = |(s_wack & ~w_wsel);
  assign w_rack_sel = |(s_rack & w_rsel);
  assign w_rack_oth = |(s_rack & ~w_rsel);
  assign w_rsd      = s_rdata[32*r_ridx +: 32];

  assign w_wto = LP_TO_EN && (r_wst == W_WAIT) &&
                 !w_wack_sel && (r_wcnt == LP_TLIM);
  assign w_rto = LP_TO_EN && (r_rst == R_WAIT) &&
                 !w_rack_sel && (r_rcnt == LP_TLIM);

  assign w_err[0] = (r_wst == W_IDLE && up_wreq && !w_wmap) ||
                    (r_rst == R_IDLE && up_rreq && !w_rmap);
  assign w_err[1] = (r_wst == W_WAIT && w_wack_sel && w_wack_oth) ||
                    (r_rst == R_WAIT && w_rack_sel && w_rack_oth);
  assign w_err[2] = (r_wst != W_IDLE && up_wreq) ||
                    (r_rst != R_IDLE && up_rreq);

  assign w_tosum = {1'b0, up_timeout_count} + 17'(w_wto) + 17'(w_rto);

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_wst   <= W_IDLE;
      r_widx  <= '0;
      r_wunm  <= 1'b0;
      r_wcnt  <= '0;
      s_wreq  <= '0;
      s_waddr <= '0;
      s_wdata <= '0;
      up_wack <= 1'b0;
    end else begin
      s_wreq  <= '0;
      up_wack <= 1'b0;
      unique case (r_wst)
        W_IDLE: if (up_wreq) begin
          if (w_wmap) begin
            s_wreq  <= w_woh;
            r_widx  <= w_widx;
            s_waddr <= up_waddr;
            s_wdata <= up_wdata;
            r_wcnt  <= '0;
            r_wst   <= W_WAIT;
          end else begin
            r_wunm <= 1'b1;
            r_wst  <= W_ACK;
          end
        end
        W_WAIT: if (w_wack_sel || w_wto) begin
          up_wack <= 1'b1;
          r_wst   <= W_ACK;
        end else if (LP_TO_EN) begin
          r_wcnt <= r_wcnt + 16'd1;
        end
        // Unmapped requests ack one cycle later, out of W_ACK.
        W_ACK: begin
          up_wack <= r_wunm;
          r_wunm  <= 1'b0;
          r_wst   <= W_IDLE;
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_rst    <= R_IDLE;
      r_ridx   <= '0;
      r_runm   <= 1'b0;
      r_rcnt   <= '0;
      s_rreq   <= '0;
      s_raddr  <= '0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      s_rreq   <= '0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
      unique case (r_rst)
        R_IDLE: if (up_rreq) begin
          if (w_rmap) begin
            s_rreq  <= w_roh;
            r_ridx  <= w_ridx;
            s_raddr <= up_raddr;
            r_rcnt  <= '0;
            r_rst   <= R_WAIT;
          end else begin
            r_runm <= 1'b1;
            r_rst  <= R_ACK;
          end
        end
        R_WAIT: if (w_rack_sel || w_rto) begin
          up_rack  <= 1'b1;
          up_rdata <= w_rack_sel ? w_rsd : ERR_RDATA;
          r_rst    <= R_ACK;
        end else if (LP_TO_EN) begin
          r_rcnt <= r_rcnt + 16'd1;
        end
        R_ACK: begin
          up_rack <= r_runm;
          r_runm  <= 1'b0;
          r_rst   <= R_IDLE;
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_err_flags     <= '0;
      up_timeout_count <= '0;
    end else begin
      up_err_flags     <= up_err_flags | w_err;
      up_timeout_count <= w_tosum[16] ? 16'hFFFF : w_tosum[15:0];
    end
  end

endmodule
